// File: rtl/k6502_pkg.sv
// Shared 6502 status-register definitions: P bit indices, branch flag
// selects and the reset value of P.
package k6502_pkg;

    localparam int SR_N = 7;
    localparam int SR_V = 6;
    localparam int SR_U = 5;
    localparam int SR_B = 4;
    localparam int SR_D = 3;
    localparam int SR_I = 2;
    localparam int SR_Z = 1;
    localparam int SR_C = 0;

    localparam logic [7:0] SR_RESET    = 8'h24;
    // Only N, V, Z and C can come from an ALU commit.
    localparam logic [7:0] SR_ALU_BITS = 8'hC3;

    // Branch opcode bits 7:6 select the tested flag.
    typedef enum logic [1:0] {
        FSEL_N = 2'b00,
        FSEL_V = 2'b01,
        FSEL_C = 2'b10,
        FSEL_Z = 2'b11
    } flag_sel_e;

    // Bit 5 always reads 1 and bit 4 (B) only exists on the stack.
    function automatic logic [7:0] sr_fix(input logic [7:0] p);
        logic [7:0] r;
        r       = p;
        r[SR_U] = 1'b1;
        r[SR_B] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/k6502_br_cond.sv
// Registered branch-condition evaluator: samples the selected flag on
// br_eval and presents the taken/not-taken result one cycle later.
module k6502_br_cond
    import k6502_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       br_eval,
    input  logic [2:0] br_cond,
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_z,
    input  logic       flag_c,
    output logic       br_valid,
    output logic       br_taken
);

    logic flag;
    logic want;

    always_comb begin
        flag = flag_n;
        want = br_cond[0];
        case (flag_sel_e'(br_cond[2:1]))
            FSEL_N:  flag = flag_n;
            FSEL_V:  flag = flag_v;
            FSEL_C:  flag = flag_c;
            FSEL_Z:  flag = flag_z;
            default: flag = flag_n;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_valid <= br_eval;
            if (br_eval) begin
                br_taken <= (flag == want);
            end
        end
    end

endmodule

// File: rtl/k6502_sr_unit.sv
// 6502 processor status register stage with delayed IRQ mask and branch
// evaluation. K6502_DECIMAL_EN exposes D on dec_mode; otherwise dec_mode is 0.
module k6502_sr_unit
    import k6502_pkg::*;
#(
    parameter logic [7:0] RESET_P = SR_RESET
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_sr,
    input  logic [7:0] alu_data,
    input  logic       upd_en,
    input  logic [7:0] upd_mask,
    input  logic       bit_en,
    input  logic [7:0] set_mask,
    input  logic [7:0] clr_mask,
    input  logic       pull_en,
    input  logic [7:0] pull_data,
    input  logic       pull_imm,
    input  logic       inst_done,
    input  logic       brk_push,
    output logic [7:0] push_data,
    output logic [7:0] sr,
    input  logic       br_eval,
    input  logic [2:0] br_cond,
    output logic       br_valid,
    output logic       br_taken,
    output logic       irq_mask,
    output logic       dec_mode
);

    logic [7:0] p_q;
    logic [7:0] p_next;
    logic [7:0] alu_src;
    logic [7:0] alu_wmask;
    logic       unused_alu_data;

    assign unused_alu_data = ^alu_data[5:0];

    // BIT routes memory bits 7:6 into N/V while Z still comes from the ALU.
    assign alu_src   = bit_en ? {alu_data[7:6], alu_sr[5:0]} : alu_sr;
    assign alu_wmask = upd_mask & SR_ALU_BITS;

    always_comb begin
        p_next = p_q;
        if (pull_en) begin
            p_next = pull_data;
        end else begin
            if (upd_en) begin
                p_next = (p_next & ~alu_wmask) | (alu_src & alu_wmask);
            end
            p_next = p_next & ~clr_mask;
            p_next = p_next | set_mask;
        end
        p_next = sr_fix(p_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= sr_fix(RESET_P);
            irq_mask <= 1'b1;
        end else begin
            p_q <= p_next;
            // RTI applies I at once; CLI/SEI/PLP wait for the instruction boundary.
            if (pull_en && pull_imm) begin
                irq_mask <= pull_data[SR_I];
            end else if (inst_done) begin
                irq_mask <= p_next[SR_I];
            end
        end
    end

    assign sr        = p_q;
    assign push_data = {p_q[7:6], 1'b1, brk_push, p_q[3:0]};

`ifdef K6502_DECIMAL_EN
    assign dec_mode = p_q[SR_D];
`else
    assign dec_mode = 1'b0;
`endif

    k6502_br_cond u_br_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .br_eval  (br_eval),
        .br_cond  (br_cond),
        .flag_n   (p_q[SR_N]),
        .flag_v   (p_q[SR_V]),
        .flag_z   (p_q[SR_Z]),
        .flag_c   (p_q[SR_C]),
        .br_valid (br_valid),
        .br_taken (br_taken)
    );

endmodule

// File: tb/tb_k6502_sr_unit.sv
// Scoreboard bench for k6502_sr_unit: directed stimulus queues expected
// values; a negedge monitor pops and compares them.
module tb_k6502_sr_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_sr, alu_data, upd_mask, set_mask, clr_mask, pull_data;
    logic       upd_en, bit_en, pull_en, pull_imm, inst_done, brk_push;
    logic [7:0] push_data, sr;
    logic       br_eval;
    logic [2:0] br_cond;
    logic       br_valid, br_taken, irq_mask, dec_mode;

    localparam int SEL_SR   = 0;
    localparam int SEL_IRQ  = 1;
    localparam int SEL_PUSH = 2;
    localparam int SEL_DEC  = 3;

`ifdef K6502_DECIMAL_EN
    localparam logic DEC_EXP_D1 = 1'b1;
`else
    localparam logic DEC_EXP_D1 = 1'b0;
`endif

    typedef struct {
        int         due;
        int         sel;
        logic [7:0] val;
        string      name;
    } chk_t;

    typedef struct {
        logic  taken;
        string name;
    } br_t;

    chk_t chk_q[$];
    br_t  br_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    k6502_sr_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_sr    (alu_sr),
        .alu_data  (alu_data),
        .upd_en    (upd_en),
        .upd_mask  (upd_mask),
        .bit_en    (bit_en),
        .set_mask  (set_mask),
        .clr_mask  (clr_mask),
        .pull_en   (pull_en),
        .pull_data (pull_data),
        .pull_imm  (pull_imm),
        .inst_done (inst_done),
        .brk_push  (brk_push),
        .push_data (push_data),
        .sr        (sr),
        .br_eval   (br_eval),
        .br_cond   (br_cond),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .irq_mask  (irq_mask),
        .dec_mode  (dec_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        chk_t       c;
        br_t        b;
        logic [7:0] act;
        while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
            c = chk_q.pop_front();
            case (c.sel)
                SEL_SR:   act = sr;
                SEL_IRQ:  act = {7'd0, irq_mask};
                SEL_PUSH: act = push_data;
                default:  act = {7'd0, dec_mode};
            endcase
            tests++;
            if (act !== c.val) begin
                fails++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.val, cyc);
            end
        end
        if (br_valid === 1'b1) begin
            tests++;
            if (br_q.size() == 0) begin
                fails++;
                $display("FAIL br_unexpected: got br_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                b = br_q.pop_front();
                if (br_taken !== b.taken) begin
                    fails++;
                    $display("FAIL %s: got br_taken=%b expected %b", b.name, br_taken, b.taken);
                end
            end
        end
    end

    task automatic exp(input int d, input int sel, input logic [7:0] v, input string n);
        chk_t c;
        c.due  = cyc + d;
        c.sel  = sel;
        c.val  = v;
        c.name = n;
        chk_q.push_back(c);
    endtask

    task automatic exp_br(input logic t, input string n);
        br_t b;
        b.taken = t;
        b.name  = n;
        br_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_sr    = 8'h00;
        alu_data  = 8'h00;
        upd_en    = 1'b0;
        upd_mask  = 8'h00;
        bit_en    = 1'b0;
        set_mask  = 8'h00;
        clr_mask  = 8'h00;
        pull_en   = 1'b0;
        pull_data = 8'h00;
        pull_imm  = 1'b0;
        inst_done = 1'b0;
        brk_push  = 1'b0;
        br_eval   = 1'b0;
        br_cond   = 3'b000;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset arrives while a branch evaluation is being requested.
        br_eval = 1'b1;
        br_cond = 3'b111;
        #2 rst_n = 1'b0;
        tick();
        br_eval = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp(0, SEL_SR, 8'h24, "rst_sr");
        exp(0, SEL_IRQ, 8'h01, "rst_irq");
        exp(0, SEL_DEC, 8'h00, "rst_dec");
        brk_push = 1'b1;
        exp(0, SEL_PUSH, 8'h34, "rst_push");
        tick();
        idle();
        tick();

        // ALU commits
        upd_en = 1'b1; upd_mask = 8'hC3; alu_sr = 8'h81;
        exp(1, SEL_SR, 8'hA5, "alu_c3");
        tick(); idle();
        upd_en = 1'b1; upd_mask = 8'h03; alu_sr = 8'h00;
        exp(1, SEL_SR, 8'hA4, "alu_03_n_kept");
        tick(); idle();
        upd_en = 1'b1; bit_en = 1'b1; upd_mask = 8'hC2; alu_sr = 8'h82; alu_data = 8'h40;
        exp(1, SEL_SR, 8'h66, "bit_nvz");
        tick(); idle();

        // CLI takes effect on irq_mask only at the boundary
        clr_mask = 8'h04;
        exp(1, SEL_SR, 8'h62, "cli_sr");
        exp(1, SEL_IRQ, 8'h01, "cli_irq_hold");
        tick(); idle();
        inst_done = 1'b1;
        exp(1, SEL_IRQ, 8'h00, "cli_irq_done");
        tick(); idle();
        set_mask = 8'h04; inst_done = 1'b1;
        exp(1, SEL_SR, 8'h66, "sei_sr");
        exp(1, SEL_IRQ, 8'h01, "sei_same_cycle_irq");
        tick(); idle();
        set_mask = 8'h01; clr_mask = 8'h01;
        exp(1, SEL_SR, 8'h67, "set_clr_overlap");
        tick(); idle();

        // Pull overrides same-cycle ALU/set/clear
        pull_en = 1'b1; pull_data = 8'hDB; upd_en = 1'b1; upd_mask = 8'hC3; clr_mask = 8'h80;
        exp(1, SEL_SR, 8'hEB, "plp_sr");
        exp(1, SEL_IRQ, 8'h01, "plp_irq_hold");
        exp(1, SEL_DEC, {7'd0, DEC_EXP_D1}, "plp_dec");
        tick(); idle();
        inst_done = 1'b1;
        exp(1, SEL_IRQ, 8'h00, "plp_irq_done");
        tick(); idle();
        pull_en = 1'b1; pull_imm = 1'b1; pull_data = 8'h04;
        exp(1, SEL_SR, 8'h24, "rti_sr");
        exp(1, SEL_IRQ, 8'h01, "rti_irq_set");
        tick(); idle();
        pull_en = 1'b1; pull_imm = 1'b1; pull_data = 8'hE3;
        exp(1, SEL_SR, 8'hE3, "rti2_sr");
        exp(1, SEL_IRQ, 8'h00, "rti2_irq_clr");
        tick(); idle();

        // Push byte
        brk_push = 1'b1;
        exp(0, SEL_PUSH, 8'hF3, "push_brk");
        tick();
        brk_push = 1'b0;
        exp(0, SEL_PUSH, 8'hE3, "push_irq");
        tick(); idle();

        // Back-to-back branch evaluations; P=E3 (N V Z C set)
        br_eval = 1'b1; br_cond = 3'b110;
        exp_br(1'b0, "bne_z1");
        tick();
        br_cond = 3'b111; upd_en = 1'b1; upd_mask = 8'h02; alu_sr = 8'h00;
        exp_br(1'b1, "beq_z1_preupd");
        tick();
        upd_en = 1'b0; upd_mask = 8'h00;
        br_cond = 3'b111;
        exp_br(1'b0, "beq_z0");
        tick();
        br_cond = 3'b001;
        exp_br(1'b1, "bmi");
        tick();
        br_cond = 3'b011;
        exp_br(1'b1, "bvs");
        tick();
        br_cond = 3'b100;
        exp_br(1'b0, "bcc");
        tick(); idle();
        exp(0, SEL_SR, 8'hE1, "z_cleared_sr");
        repeat (4) tick();

        tests++;
        if (chk_q.size() != 0 || br_q.size() != 0) begin
            fails++;
            $display("FAIL pending: got %0d/%0d unchecked entries expected 0/0", chk_q.size(), br_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/k6502_sr_unit.md
Name: k6502_sr_unit

Overview:
- Processor status register (P) stage directly downstream of the ALU; the ALU's sr input is driven from this block's sr output.
- Merges ALU flag results (N,V,Z,C) under a per-instruction write mask.
- Also handles:
  - flag set/clear instructions;
  - PLP/RTI pulls and PHP/BRK pushes;
  - BIT flag transfer;
  - registered branch-condition evaluation;
  - the instruction-boundary-delayed IRQ mask.

Parameters:
- RESET_P, 8'h24, P value after reset (bit5=1, I=1, all others 0).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- alu_sr  in  8  ALU flag bus {N,V,0,0,0,0,Z,C}.
- alu_data  in  8  ALU data output; bits 7:6 feed N/V on BIT.
- upd_en  in  1  commit ALU flags this cycle.
- upd_mask  in  8  flags (bit positions as in P) written from alu_sr on upd_en.
- bit_en  in  1  with upd_en: N<=alu_data[7], V<=alu_data[6]; Z still from alu_sr.
- set_mask  in  8  one-hot or zero; flags to set (SEC/SEI/SED).
- clr_mask  in  8  one-hot or zero; flags to clear (CLC/CLI/CLD/CLV).
- pull_en  in  1  load P from pull_data (PLP/RTI).
- pull_data  in  8  byte pulled from stack.
- pull_imm  in  1  with pull_en: irq_mask updates immediately (RTI).
- inst_done  in  1  instruction-boundary strobe.
- brk_push  in  1  selects B=1 in push_data (PHP/BRK=1, IRQ/NMI=0).
- push_data  out  8  {P[7:6],1,brk_push,P[3:0]}; combinational.
- sr  out  8  current P with bit5=1, B(bit4)=0; drives ALU sr.
- br_eval  in  1  request branch evaluation.
- br_cond  in  3  opcode bits 7:5 {flag_sel[1:0], want}.
- br_valid  out  1  one-cycle pulse, one cycle after br_eval.
- br_taken  out  1  result; holds until next br_valid.
- irq_mask  out  1  effective I used by interrupt logic.
- dec_mode  out  1  D flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n low):
  - P<=RESET_P.
  - irq_mask<=1, br_valid<=0, br_taken<=0.
  - Reset mid-operation aborts any pending evaluation; no pulse after release.
- Stored bits:
  - P bits 7,6,3,2,1,0 are stored.
  - Bit5 reads 1 always; bit4 is never stored and reads 0 on sr.
- Per-cycle next-P, priority high to low:
  1. pull_en: P<=pull_data (bits 5,4 ignored); upd_en, set_mask and clr_mask are ignored that cycle.
  2. Else apply upd_en, then clr_mask, then set_mask, in that order on the same cycle (set wins on overlap).
- upd_en:
  - For each bit b with upd_mask[b]=1: P[b]<=alu_sr[b].
  - If bit_en: bits 7,6 come from alu_data instead.
  - Mask bits 5,4,3,2 are ignored.
- BRK/IRQ entry: setting I is done via set_mask=8'h04 in the cycle the vector fetch starts.
- irq_mask:
  - On inst_done: irq_mask<=next-P[I] (same-cycle updates included).
  - On pull_en with pull_imm: irq_mask<=pull_data[2] that cycle.
  - Otherwise holds. This gives the 6502 one-instruction delay for CLI/SEI/PLP.
- Branch evaluation:
  - On br_eval, sample flag F from current (pre-update) P: flag_sel 00=N, 01=V, 10=C, 11=Z.
  - Next cycle: br_taken<=(F==want), br_valid<=1.
  - Back-to-back br_eval gives back-to-back pulses.
- Latency:
  - P updates visible on sr the cycle after the commit edge.
  - push_data follows sr combinationally.

Optional Feature:
- Macro: K6502_DECIMAL_EN.
- Defined:
  - D (bit3) is stored and written by set/clr/pull.
  - dec_mode=P[3].
- Undefined (NES 2A03 build):
  - D is still stored and pushed (software-visible).
  - dec_mode tied 0, so the ALU never enters BCD.

Decomposition:
- Shared package k6502_pkg:
  - SR bit indices (SR_N=7, SR_V=6, SR_U=5, SR_B=4, SR_D=3, SR_I=2, SR_Z=1, SR_C=0).
  - Branch flag_sel encodings.
  - Reset constant 8'h24.
- One sub-module, k6502_br_cond: registered flag-select/compare producing br_valid/br_taken.

Test Plan:
- Reset: assert rst_n=0 mid-branch-eval -> sr=8'h24, irq_mask=1, no br_valid after release.
- ALU commit: upd_en, upd_mask=8'hC3, alu_sr=8'h81 -> sr=8'hA5 next cycle (N,C set, I kept); with upd_mask=8'h03 the N bit is unchanged.
- Set/clear and IRQ delay:
  - From sr=8'h24: clr_mask=8'h04 (CLI) -> sr=8'h20, but irq_mask stays 1 until inst_done, then 0.
  - Simultaneous set_mask=clr_mask=8'h01 -> C=1.
- Pull:
  - pull_en, pull_data=8'hDB, pull_imm=0, plus simultaneous upd_en -> sr=8'hEB (bit4 dropped, bit5 forced), upd ignored; irq_mask unchanged until inst_done.
  - With pull_imm=1 -> irq_mask changes the same edge.
- Push: P=8'hE3, brk_push=1 -> push_data=8'hF3; brk_push=0 -> 8'hE3.
- Branch: P.Z=1, br_eval with br_cond=3'b111 (BEQ) -> br_valid pulse next cycle, br_taken=1; br_cond=3'b110 (BNE) -> br_taken=0; a same-cycle upd_en clearing Z does not affect the result.
